// File: rtl/band_sequencer.sv
// Stereo sample queue and tap sequencer for a FIR band engine.
// Holds the last NUM_TAPS samples and streams them oldest->newest once per new sample.
module band_sequencer #(
    parameter int NUM_TAPS = 1023,
    parameter int AW       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [15:0] lft_in,
    input  logic [15:0] rght_in,
    input  logic        ovr_clr,
    output logic        sequencing,
    output logic [15:0] lft_smpl,
    output logic [15:0] rght_smpl,
    output logic        done,
    output logic        full,
    output logic        overrun
);

    // One extra bit so the cycle counter reaches NUM_TAPS+1 even at NUM_TAPS=1023.
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {FILL, IDLE, SEQ, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr, wr_inc, rd_inc;
    logic [CW-1:0]   fill_cnt, cyc;
    logic [31:0]     mem [0:(1<<AW)-1];
    logic [31:0]     rd_data;
    logic            full_r, ovr_r;
    logic            wr_en;

    assign wr_en = vld && (state == FILL || state == IDLE);

    always_comb begin
        wr_inc = (wr_ptr == AW'(NUM_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
        rd_inc = (rd_ptr == AW'(NUM_TAPS - 1)) ? '0 : rd_ptr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (vld && fill_cnt == CW'(NUM_TAPS - 1)) state_nxt = IDLE;
            IDLE:    if (vld) state_nxt = SEQ;
            SEQ:     if (cyc == CW'(NUM_TAPS + 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        sequencing = (state == SEQ);
        done       = (state == DONE);
        full       = full_r;
        overrun    = ovr_r;
        lft_smpl   = rd_data[31:16];
        rght_smpl  = rd_data[15:0];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {lft_in, rght_in};
    end

    // Read pointer stalls on c=0 so the registered read of rd_base lands on c=2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            cyc      <= '0;
            rd_data  <= '0;
            full_r   <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_inc;
            if (state == FILL && vld) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == CW'(NUM_TAPS - 1)) full_r <= 1'b1;
            end
            if (state == IDLE && vld) begin
                rd_ptr <= wr_inc;
                cyc    <= '0;
            end
            if (state == SEQ) begin
                cyc <= cyc + 1'b1;
                if (cyc < CW'(NUM_TAPS + 1)) rd_data <= mem[rd_ptr];
                if (cyc != '0) rd_ptr <= rd_inc;
            end
            if (vld && (state == SEQ || state == DONE)) ovr_r <= 1'b1;
            else if (ovr_clr)                           ovr_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_band_sequencer.sv
// Bench for band_sequencer at NUM_TAPS=8: queue/timeline model checked every cycle,
// plus directed literal expectations.
module tb_band_sequencer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        ovr_clr = 1'b0;
    logic [15:0] lft_in = '0;
    logic [15:0] rght_in = '0;
    logic        sequencing, done, full, overrun;
    logic [15:0] lft_smpl, rght_smpl;

    band_sequencer #(.NUM_TAPS(N), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .lft_in(lft_in), .rght_in(rght_in),
        .ovr_clr(ovr_clr), .sequencing(sequencing), .lft_smpl(lft_smpl),
        .rght_smpl(rght_smpl), .done(done), .full(full), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of accepted samples, a snapshot per run, and the run's age in cycles
    // (0..N+1 sequencing, N+2 the done cycle, -1 when no run).
    logic [15:0] hist_l[$], hist_r[$], snap_l[$], snap_r[$];
    bit          m_full = 0;
    bit          m_ovr  = 0;
    int          run_t  = -1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            hist_l.delete(); hist_r.delete();
            m_full = 0; m_ovr = 0; run_t = -1;
        end else begin
            bit busy, new_run;
            busy    = (run_t >= 0);
            new_run = 0;
            if (vld && busy) begin
                m_ovr = 1;
            end else begin
                if (ovr_clr) m_ovr = 0;
                if (vld) begin
                    hist_l.push_back(lft_in);
                    hist_r.push_back(rght_in);
                    if (hist_l.size() > N) begin
                        void'(hist_l.pop_front());
                        void'(hist_r.pop_front());
                    end
                    if (!m_full) begin
                        if (hist_l.size() == N) m_full = 1;
                    end else begin
                        new_run = 1;
                    end
                end
            end
            if (run_t >= 0) run_t = (run_t == N + 2) ? -1 : run_t + 1;
            if (new_run) begin
                run_t  = 0;
                snap_l = hist_l;
                snap_r = hist_r;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("seq", {15'd0, sequencing}, {15'd0, (run_t >= 0 && run_t <= N + 1)});
            chk("done", {15'd0, done}, {15'd0, (run_t == N + 2)});
            chk("full", {15'd0, full}, {15'd0, m_full});
            chk("overrun", {15'd0, overrun}, {15'd0, m_ovr});
            if (run_t >= 2 && run_t <= N + 1) begin
                chk("lft_smpl", lft_smpl, snap_l[run_t - 2]);
                chk("rght_smpl", rght_smpl, snap_r[run_t - 2]);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        vld = 1'b1; lft_in = l; rght_in = r;
        step;
        vld = 1'b0;
    endtask

    task automatic wait_done;
        bit seen = 0;
        for (int i = 0; i < 3 * N; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            step;
        end
        chk("wait_done", {15'd0, seen}, 16'd1);
    endtask

    initial begin
        step; step;
        chk("rst_seq", {15'd0, sequencing}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_full", {15'd0, full}, 16'd0);
        chk("rst_ovr", {15'd0, overrun}, 16'd0);
        chk("rst_lft", lft_smpl, 16'd0);
        chk("rst_rght", rght_smpl, 16'd0);
        rst_n = 1'b1;
        step;

        // Fill: 7 samples leave the queue not full, the 8th fills it without a run.
        for (int i = 1; i <= 7; i++) begin
            send(16'(i), 16'(-i));
            step;
        end
        chk("fill7_full", {15'd0, full}, 16'd0);
        send(16'd8, 16'(-8));
        step;
        chk("fill8_full", {15'd0, full}, 16'd1);
        chk("fill8_seq", {15'd0, sequencing}, 16'd0);

        // First run: samples 2..9 on c=2..9, done at c=10.
        send(16'd9, 16'(-9));
        for (int k = 0; k <= 9; k++) begin
            chk("run1_seq", {15'd0, sequencing}, 16'd1);
            if (k >= 2) begin
                chk("run1_lft", lft_smpl, 16'(k));
                chk("run1_rght", rght_smpl, 16'(-k));
            end
            step;
        end
        chk("run1_done", {15'd0, done}, 16'd1);
        chk("run1_seq_low", {15'd0, sequencing}, 16'd0);
        step;
        chk("run1_done_end", {15'd0, done}, 16'd0);

        // Wrap-around runs.
        for (int s = 10; s <= 20; s++) begin
            send(16'(s), 16'(-s));
            wait_done;
            step;
        end

        // Overrun at c=4; dropped sample must not appear in the next run.
        send(16'd21, 16'(-21));
        step; step; step; step;
        send(16'd99, 16'(-99));
        chk("ovr_set", {15'd0, overrun}, 16'd1);
        wait_done;
        step;
        send(16'd22, 16'(-22));
        step; step;
        chk("after_drop_lft", lft_smpl, 16'd15);
        wait_done;
        step;
        ovr_clr = 1'b1;
        step;
        ovr_clr = 1'b0;
        chk("ovr_clr", {15'd0, overrun}, 16'd0);
        send(16'd23, 16'(-23));
        step;
        vld = 1'b1; ovr_clr = 1'b1; lft_in = 16'd77; rght_in = 16'd78;
        step;
        vld = 1'b0; ovr_clr = 1'b0;
        chk("ovr_set_wins", {15'd0, overrun}, 16'd1);
        wait_done;
        step;

        // Async reset at c=5.
        send(16'd24, 16'(-24));
        step; step; step; step; step;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seq", {15'd0, sequencing}, 16'd0);
        chk("mid_rst_done", {15'd0, done}, 16'd0);
        chk("mid_rst_full", {15'd0, full}, 16'd0);
        chk("mid_rst_ovr", {15'd0, overrun}, 16'd0);
        step;
        rst_n = 1'b1;
        step;
        for (int i = 30; i <= 36; i++) begin
            send(16'(i), 16'(-i));
            step;
        end
        chk("refill7_full", {15'd0, full}, 16'd0);
        send(16'd37, 16'(-37));
        step;
        chk("refill8_full", {15'd0, full}, 16'd1);
        send(16'd38, 16'(-38));
        step; step;
        chk("refill_run_lft", lft_smpl, 16'd31);
        wait_done;
        step; step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
